// File: rtl/imem_stream_loader.sv
// imem_stream_loader: byte-stream program loader for the MIPS instruction memory.
// Frame: 16-bit word count N (high byte first), then N big-endian 32-bit words.
// The CPU is held while a load is in progress and released once it completes.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN: a trailing XOR checksum byte
// covers every earlier frame byte, including both length bytes.
module imem_stream_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned CW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  // State entered once the last word (or an empty frame) has been handled.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t          state, state_nxt;
  logic [7:0]      n_hi;
  logic [CW-1:0]   len;
  logic [CW-1:0]   idx;
  logic [1:0]      bcnt;
  logic [23:0]     word;
  logic [15:0]     n_full;
  logic            hs;
  logic            last;
  logic            start_ok;
  logic            ready_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign hs       = byte_valid & byte_ready;
  assign n_full   = {n_hi, byte_data};
  assign last     = (idx == len - CW'(1));
  assign start_ok = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and the registered-output predicate for byte_ready.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN_HI;
      S_LEN_HI: if (hs) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (hs) begin
          if (32'(n_full) > DEPTH) state_nxt = S_ERR;
          else if (n_full == '0)   state_nxt = S_FIN;
          else                     state_nxt = S_DATA;
        end
      end
      S_DATA: if (hs && bcnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last ? S_FIN : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (hs) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
`endif
      default: state_nxt = S_IDLE;
    endcase

    ready_nxt = (state_nxt == S_LEN_HI) | (state_nxt == S_LEN_LO) | (state_nxt == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_nxt = ready_nxt | (state_nxt == S_CHK);
`endif
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ready <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      byte_ready <= ready_nxt;
      cpu_hold   <= (state_nxt != S_DONE);
      done       <= (state_nxt == S_DONE);
      error      <= (state_nxt == S_ERR);
    end
  end

  // Datapath: length capture, word assembly, write port and word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_hi     <= '0;
      len      <= '0;
      idx      <= '0;
      bcnt     <= '0;
      word     <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      im_we <= 1'b0;
      if (start_ok) begin
        idx  <= '0;
        bcnt <= '0;
      end
      unique case (state)
        S_LEN_HI: if (hs) n_hi <= byte_data;
        S_LEN_LO: if (hs) begin
          len  <= CW'(n_full);
          idx  <= '0;
          bcnt <= '0;
        end
        S_DATA: if (hs) begin
          word <= {word[15:0], byte_data};
          bcnt <= bcnt + 2'd1;
          // The write port is loaded on the 4th byte so im_we lands in S_WRITE.
          if (bcnt == 2'd3) begin
            im_we    <= 1'b1;
            im_addr  <= idx[ADDR_W-1:0];
            im_wdata <= {word, byte_data};
          end
        end
        S_WRITE: idx <= idx + CW'(1);
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of every frame byte before the checksum byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                               csum <= '0;
    else if (start_ok)                                        csum <= '0;
    else if (hs && (state == S_LEN_HI || state == S_LEN_LO || state == S_DATA))
                                                              csum <= csum ^ byte_data;
  end
`endif

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed self-checking bench for imem_stream_loader (ADDR_W = 8).
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [7:0]  fq[$];
  logic [7:0]  wa[$];
  logic [31:0] wd[$];

  imem_stream_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Log every memory write seen by the instruction memory.
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      wa.push_back(im_addr);
      wd.push_back(im_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_data  = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      chk("ready_timeout", 32'(byte_ready), 32'd1);
      byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int gap);
    foreach (fq[i]) send_byte(fq[i], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) chk("end_timeout", 32'(done | error), 32'd1);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic load_two_word_frame();
    fq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
`ifdef IMEM_LOADER_CHECKSUM_EN
    fq.push_back(8'h0C);
`endif
  endtask

  task automatic check_two_words(input string tag);
    chk({tag, "_nwr"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, 32'(wa[0]), 32'd0);
      chk({tag, "_d0"}, wd[0], 32'h20080005);
      chk({tag, "_a1"}, 32'(wa[1]), 32'd1);
      chk({tag, "_d1"}, wd[1], 32'h2009000A);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(error), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_rdy"}, 32'(byte_ready), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rdy"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(im_we), 32'd0);
    chk({tag, "_addr"}, 32'(im_addr), 32'd0);
    chk({tag, "_wdata"}, im_wdata, 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(error), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("idle");

    // Back-to-back two-word frame, with a latency check on the first word.
    clear_log();
    pulse_start();
    chk("start_rdy", 32'(byte_ready), 32'd1);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    chk("lat_we", 32'(im_we), 32'd1);
    chk("lat_wdata", im_wdata, 32'h20080005);
    send_byte(8'h20, 0); send_byte(8'h09, 0); send_byte(8'h00, 0); send_byte(8'h0A, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h0C, 0);
`endif
    wait_end();
    check_two_words("f2");
    chk("f2_addr_hold", 32'(im_addr), 32'd1);

    // Same frame with 3-cycle gaps and a stray start in the middle.
    clear_log();
    load_two_word_frame();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(fq[i], 3);
    pulse_start();
    for (int i = 3; i < fq.size(); i++) send_byte(fq[i], 3);
    wait_end();
    check_two_words("gap");

    // Empty frame.
    clear_log();
    fq = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    fq.push_back(8'h00);
`endif
    pulse_start();
    chk("n0_hold_run", 32'(cpu_hold), 32'd1);
    chk("n0_done_clr", 32'(done), 32'd0);
    send_frame(0);
    wait_end();
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_nwr", 32'(wa.size()), 32'd0);

    // Oversize length: 257 words for a 256-word memory.
    clear_log();
    fq = '{8'h01, 8'h01};
    pulse_start();
    send_frame(0);
    wait_end();
    chk("big_err", 32'(error), 32'd1);
    chk("big_hold", 32'(cpu_hold), 32'd1);
    chk("big_done", 32'(done), 32'd0);
    chk("big_rdy", 32'(byte_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("big_nwr", 32'(wa.size()), 32'd0);
    pulse_start();
    chk("big_err_clr", 32'(error), 32'd0);
    load_two_word_frame();
    send_frame(0);
    wait_end();
    check_two_words("recov");

    // Full memory: 256 words, word i = {i,i,i,i}; checksum is 01.
    clear_log();
    fq = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) repeat (4) fq.push_back(8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
    fq.push_back(8'h01);
`endif
    pulse_start();
    send_frame(0);
    wait_end();
    chk("full_done", 32'(done), 32'd1);
    chk("full_nwr", 32'(wa.size()), 32'd256);
    if (wa.size() == 256) begin
      chk("full_a255", 32'(wa[255]), 32'd255);
      chk("full_d255", wd[255], 32'hFFFFFFFF);
      chk("full_a128", 32'(wa[128]), 32'd128);
      chk("full_d128", wd[128], 32'h80808080);
    end

    // Reset after the 2nd data byte, then a fresh load.
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h20, 0); send_byte(8'h08, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("midrst_idle");
    chk("midrst_nwr", 32'(wa.size()), 32'd0);
    load_two_word_frame();
    pulse_start();
    send_frame(0);
    wait_end();
    check_two_words("fresh");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // One-word frame with good and bad checksum bytes.
    clear_log();
    fq = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    pulse_start();
    send_frame(0);
    wait_end();
    chk("ck_good_done", 32'(done), 32'd1);
    chk("ck_good_err", 32'(error), 32'd0);
    clear_log();
    fq = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    pulse_start();
    send_frame(0);
    wait_end();
    chk("ck_bad_err", 32'(error), 32'd1);
    chk("ck_bad_done", 32'(done), 32'd0);
    chk("ck_bad_hold", 32'(cpu_hold), 32'd1);
    chk("ck_bad_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("ck_bad_a0", 32'(wa[0]), 32'd0);
      chk("ck_bad_d0", wd[0], 32'h20080005);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
